// File: rtl/fp_pack_round.sv
// rtl/fp_pack_round.sv - round-to-nearest-even and IEEE-754 pack, one double or two singles, 2-stage pipe
//
// Purpose: final stage of the dual-mode FP add datapath. Stage 1 rounds each
// lane's mantissa (RNE from guard/round/sticky), stage 2 resolves special
// cases and packs the 64-bit result word.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   i_valid / i_ready     input handshake
//   i_mode                1 = one double (lane 0), 0 = two singles
//   i_sign[1:0]           per-lane sign
//   i_exp[15:0]           biased exponents (single: [7:0],[15:8]; double: [10:0])
//   i_frac53[52:0]        mantissas incl. hidden bit (single lane1 in [52:29])
//   i_grs[5:0]            guard/round/sticky, lane1 = [5:3], lane0 = [2:0]
//   i_nan, i_inf, i_zero  per-lane special results
//   o_valid / o_ready     output handshake
//   o_result[63:0]        packed result
//   o_flags[3:0]          {ovf1, inx1, ovf0, inx0}

module fp_pack_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_mode,
  input  logic [1:0]  i_sign,
  input  logic [15:0] i_exp,
  input  logic [52:0] i_frac53,
  input  logic [5:0]  i_grs,
  input  logic [1:0]  i_nan,
  input  logic [1:0]  i_inf,
  input  logic [1:0]  i_zero,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_result,
  output logic [3:0]  o_flags
);

  // Single-mode lane 1 padding bits carry no information.
  logic unused_pad;
  assign unused_pad = ^i_frac53[28:24];

  // Whole pipe advances together; a stalled output freezes both stages.
  logic en;
  assign en      = o_ready | ~o_valid;
  assign i_ready = en;

  // RNE on one single lane; returns {exp, fraction without hidden bit}.
  function automatic logic [30:0] round_s(input logic [7:0] e, input logic [23:0] m,
                                          input logic [2:0] grs);
    logic        up;
    logic [24:0] mr;
    logic [7:0]  eo;
    logic [22:0] fo;
    up = grs[2] & (grs[1] | grs[0] | m[0]);
    mr = {1'b0, m} + {24'd0, up};
    eo = e;
    fo = mr[22:0];
    if (mr[24]) begin
      // mantissa overflowed past the hidden bit: renormalise
      eo = e + 8'd1;
      fo = '0;
    end else if (e == 8'd0 && mr[23]) begin
      // subnormal rounded up into the normal range
      eo = 8'd1;
    end
    return {eo, fo};
  endfunction

  // Special handling and pack for one single lane; returns {ovf, inx, word}.
  function automatic logic [33:0] pack_s(input logic s, input logic nan, input logic inf,
                                         input logic zero, input logic inx,
                                         input logic [7:0] e, input logic [22:0] f);
    if (nan)                 return {2'b00, 32'h7FC0_0000};
    else if (inf)            return {2'b00, s, 8'hFF, 23'd0};
    else if (zero)           return {2'b00, s, 31'd0};
    else if (e == 8'hFF)     return {2'b11, s, 8'hFF, 23'd0};
    else                     return {1'b0, inx, s, e, f};
  endfunction

  // Stage 1 combinational rounding (double lane).
  logic        up_d;
  logic [53:0] md;
  logic [10:0] ed_n;
  logic [51:0] fd_n;
  logic [30:0] r0_n, r1_n;

  always_comb begin
    up_d = i_grs[2] & (i_grs[1] | i_grs[0] | i_frac53[0]);
    md   = {1'b0, i_frac53} + {53'd0, up_d};
    ed_n = i_exp[10:0];
    fd_n = md[51:0];
    if (md[53]) begin
      ed_n = i_exp[10:0] + 11'd1;
      fd_n = '0;
    end else if (i_exp[10:0] == 11'd0 && md[52]) begin
      ed_n = 11'd1;
    end
    r0_n = round_s(i_exp[7:0], i_frac53[23:0], i_grs[2:0]);
    r1_n = round_s(i_exp[15:8], {i_frac53[52], i_frac53[51:29]}, i_grs[5:3]);
  end

  // Stage 1 registers
  logic        v1, mode1;
  logic [1:0]  sign1, nan1, inf1, zero1, inx1;
  logic [10:0] ed1;
  logic [51:0] fd1;
  logic [30:0] r0_1, r1_1;

  // Stage 2 combinational pack
  logic [33:0] p0, p1;
  logic [63:0] res_n;
  logic [3:0]  flg_n;

  always_comb begin
    p0 = pack_s(sign1[0], nan1[0], inf1[0], zero1[0], inx1[0], r0_1[30:23], r0_1[22:0]);
    p1 = pack_s(sign1[1], nan1[1], inf1[1], zero1[1], inx1[1], r1_1[30:23], r1_1[22:0]);
    res_n = {p1[31:0], p0[31:0]};
    flg_n = {p1[33:32], p0[33:32]};
    if (mode1) begin
      flg_n = 4'b0000;
      if (nan1[0]) begin
        res_n = 64'h7FF8_0000_0000_0000;
      end else if (inf1[0]) begin
        res_n = {sign1[0], 11'h7FF, 52'd0};
      end else if (zero1[0]) begin
        res_n = {sign1[0], 63'd0};
      end else if (ed1 == 11'h7FF) begin
        res_n = {sign1[0], 11'h7FF, 52'd0};
        flg_n = 4'b0011;
      end else begin
        res_n = {sign1[0], ed1, fd1};
        flg_n = {3'b000, inx1[0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      mode1    <= 1'b0;
      sign1    <= '0;
      nan1     <= '0;
      inf1     <= '0;
      zero1    <= '0;
      inx1     <= '0;
      ed1      <= '0;
      fd1      <= '0;
      r0_1     <= '0;
      r1_1     <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else if (en) begin
      v1       <= i_valid;
      mode1    <= i_mode;
      sign1    <= i_sign;
      nan1     <= i_nan;
      inf1     <= i_inf;
      zero1    <= i_zero;
      inx1     <= {|i_grs[5:3], |i_grs[2:0]};
      ed1      <= ed_n;
      fd1      <= fd_n;
      r0_1     <= r0_n;
      r1_1     <= r1_n;
      o_valid  <= v1;
      o_result <= res_n;
      o_flags  <= flg_n;
    end
  end

endmodule

// File: tb/tb_fp_pack_round.sv
// tb/tb_fp_pack_round.sv - scoreboard bench for fp_pack_round with randomized traffic

module tb_fp_pack_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_mode;
  logic [1:0]  i_sign, i_nan, i_inf, i_zero;
  logic [15:0] i_exp;
  logic [52:0] i_frac53;
  logic [5:0]  i_grs;
  logic        o_valid, o_ready;
  logic [63:0] o_result;
  logic [3:0]  o_flags;

  fp_pack_round dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode),
    .i_sign(i_sign), .i_exp(i_exp), .i_frac53(i_frac53), .i_grs(i_grs),
    .i_nan(i_nan), .i_inf(i_inf), .i_zero(i_zero), .o_valid(o_valid),
    .o_ready(o_ready), .o_result(o_result), .o_flags(o_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_bp = 0;
  int   stall_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: value-level rounding. The mantissa is treated as an integer
  // scaled by 2^(eff-bias-fb); rounding may double it, which is renormalised.
  function automatic void model_lane(input int fb, input longint unsigned m, input int e,
                                     input logic [2:0] grs, input bit s, input bit nan,
                                     input bit inf, input bit zero,
                                     output longint unsigned bits, output bit ovf,
                                     output bit inx);
    int ew, emax, eff, ef;
    longint unsigned hid, mm, fr, infbits, sbit;
    bit up;
    ew      = (fb == 23) ? 8 : 11;
    emax    = (1 << ew) - 1;
    hid     = 64'd1 << fb;
    sbit    = longint'(s) << (fb + ew);
    infbits = sbit | (longint'(emax) << fb);
    ovf = 0;
    inx = 0;
    if (nan) begin
      bits = (fb == 23) ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
    end else if (inf) begin
      bits = infbits;
    end else if (zero) begin
      bits = sbit;
    end else begin
      eff = (e == 0) ? 1 : e;
      up  = grs[2] && (grs[1] || grs[0] || (m % 2 == 1));
      mm  = m + (up ? 1 : 0);
      if (mm >= 2 * hid) begin
        mm  = mm / 2;
        eff = eff + 1;
      end
      if (mm >= hid) begin
        ef = eff;
        fr = mm - hid;
      end else begin
        ef = 0;
        fr = mm;
      end
      inx = (grs != 3'b000);
      if (ef >= emax) begin
        bits = infbits;
        ovf  = 1;
      end else begin
        bits = sbit | (longint'(ef) << fb) | fr;
      end
    end
  endfunction

  function automatic void model(input logic mode, input logic [1:0] sg, input logic [15:0] ex,
                                input logic [52:0] fr, input logic [5:0] gr,
                                input logic [1:0] na, input logic [1:0] nf,
                                input logic [1:0] ze, output logic [63:0] res,
                                output logic [3:0] flg);
    longint unsigned b0, b1;
    bit o0, x0, o1, x1;
    if (mode) begin
      model_lane(52, longint'(fr), int'(ex[10:0]), gr[2:0], sg[0], na[0], nf[0], ze[0],
                 b0, o0, x0);
      res = b0;
      flg = {2'b00, o0, x0};
    end else begin
      model_lane(23, longint'(fr[23:0]), int'(ex[7:0]), gr[2:0], sg[0], na[0], nf[0], ze[0],
                 b0, o0, x0);
      model_lane(23, longint'(fr[52:29]), int'(ex[15:8]), gr[5:3], sg[1], na[1], nf[1], ze[1],
                 b1, o1, x1);
      res = {b1[31:0], b0[31:0]};
      flg = {o1, x1, o0, x0};
    end
  endfunction

  task automatic send(input logic mode, input logic [1:0] sg, input logic [15:0] ex,
                      input logic [52:0] fr, input logic [5:0] gr, input logic [1:0] na,
                      input logic [1:0] nf, input logic [1:0] ze, input bit lat,
                      input bit use_x, input logic [63:0] xr, input logic [3:0] xf);
    exp_t e;
    int   n;
    bit   done;
    i_valid = 1'b1; i_mode = mode; i_sign = sg; i_exp = ex; i_frac53 = fr;
    i_grs = gr; i_nan = na; i_inf = nf; i_zero = ze;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (i_ready) begin
        done = 1;
        if (use_x) begin
          e.res = xr;
          e.flg = xf;
        end else begin
          model(mode, sg, ex, fr, gr, na, nf, ze, e.res, e.flg);
        end
        e.acc = cyc;
        e.lat = lat;
        q.push_back(e);
      end else if (n > 200) begin
        done = 1;
        checks++;
        errors++;
        $display("FAIL accept_timeout i_ready stayed %b, required 1", i_ready);
      end else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic gen_lane(input int fb, output longint unsigned m, output int e);
    int emax, k;
    longint unsigned hid, fr;
    emax = (fb == 23) ? 255 : 2047;
    hid  = 64'd1 << fb;
    fr   = {$urandom, $urandom} & (hid - 1);
    k    = $urandom_range(0, 9);
    if (k == 0) begin
      e = 0; m = fr;
    end else if (k == 1) begin
      e = emax - 1; m = 2 * hid - 1;
    end else if (k == 2) begin
      e = emax - 1; m = hid | fr;
    end else begin
      e = $urandom_range(1, emax - 1); m = hid | fr;
    end
  endtask

  task automatic rand_send();
    logic        mode;
    logic [15:0] ex;
    logic [52:0] fr;
    logic [1:0]  na, nf, ze;
    longint unsigned m0, m1;
    int e0, e1;
    mode = $urandom_range(0, 2) == 0;
    if (mode) begin
      gen_lane(52, m0, e0);
      ex = {5'($urandom), 11'(e0)};
      fr = 53'(m0);
    end else begin
      gen_lane(23, m0, e0);
      gen_lane(23, m1, e1);
      ex = {8'(e1), 8'(e0)};
      fr = {24'(m1), 5'($urandom), 24'(m0)};
    end
    for (int l = 0; l < 2; l++) begin
      na[l] = ($urandom_range(0, 15) == 0);
      nf[l] = ($urandom_range(0, 15) == 0);
      ze[l] = ($urandom_range(0, 15) == 0);
    end
    send(mode, 2'($urandom), ex, fr, 6'($urandom), na, nf, ze, 0, 0, '0, '0);
  endtask

  // Monitor: pops the scoreboard on each consumed output, checks hold under stall.
  logic [63:0] held_res;
  logic [3:0]  held_flg;
  bit          stall_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (o_valid !== 1'b1 || o_result !== held_res || o_flags !== held_flg) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h/%h, required v=1 %h/%h",
                   o_valid, o_result, o_flags, held_res, held_flg);
        end
      end
      if (o_valid && !o_ready) begin
        stall_seen++;
        checks++;
        if (i_ready !== 1'b0) begin
          errors++;
          $display("FAIL i_ready_stall got %b, required 0", i_ready);
        end
        stall_prev = 1;
        held_res = o_result;
        held_flg = o_flags;
      end else begin
        stall_prev = 0;
      end
      if (o_valid && o_ready) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h, required no output", o_result);
        end else begin
          e = q.pop_front();
          if (o_result !== e.res || o_flags !== e.flg) begin
            errors++;
            $display("FAIL result got %h flags %b, required %h flags %b",
                     o_result, o_flags, e.res, e.flg);
          end
          if (e.lat) begin
            checks++;
            if (cyc != e.acc + 2) begin
              errors++;
              $display("FAIL latency got %0d, required 2", cyc - e.acc);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; i_valid = 0; i_mode = 0; i_sign = 0; i_exp = 0; i_frac53 = 0;
    i_grs = 0; i_nan = 0; i_inf = 0; i_zero = 0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_result", o_result, 64'd0);
    chk("reset_o_flags", 64'(o_flags), 64'd0);
    chk("reset_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    o_ready = 1'b1;

    // Directed cases
    send(1, 2'b00, 16'h03FF, 53'd1 << 52, 6'b000, 0, 0, 0, 1, 1,
         64'h3FF0_0000_0000_0000, 4'b0000);
    send(0, 2'b01, 16'h7F80, {24'h800000, 5'd0, 24'h800000}, 6'b000, 0, 0, 0, 1, 1,
         64'h3F80_0000_C000_0000, 4'b0000);
    send(0, 2'b00, 16'h007F, {24'h0, 5'd0, 24'hFFFFFF}, 6'b000_100, 0, 0, 2'b10, 1, 1,
         64'h0000_0000_4000_0000, 4'b0001);
    send(0, 2'b00, 16'h007F, {24'h0, 5'd0, 24'h800000}, 6'b000_100, 0, 0, 2'b10, 1, 1,
         64'h0000_0000_3F80_0000, 4'b0001);
    send(1, 2'b00, 16'h07FE, {53{1'b1}}, 6'b000_110, 0, 0, 0, 1, 1,
         64'h7FF0_0000_0000_0000, 4'b0011);
    send(0, 2'b01, 16'h0000, 53'd0, 6'b111_111, 2'b10, 2'b10, 2'b01, 1, 1,
         64'h7FC0_0000_8000_0000, 4'b0000);

    // Backpressure: 4 back-to-back with a 3-cycle stall mid-stream
    n = stall_seen;
    fork
      begin
        for (int k = 0; k < 4; k++) rand_send();
      end
      begin
        repeat (3) @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 o_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stall_observed", 64'(stall_seen > n), 64'd1);

    // Reset with two transactions in flight
    rand_send();
    rand_send();
    chk("inflight_valid", 64'(o_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 64'(o_valid), 64'd0);
    chk("async_reset_result", o_result, 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(1, 2'b01, 16'h0400, 53'd1 << 52, 6'b000, 0, 0, 0, 1, 1,
         64'hC000_0000_0000_0000, 4'b0000);

    // Randomized traffic with random backpressure and input gaps
    rand_bp = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      rand_send();
    end
    rand_bp = 0;
    @(posedge clk); #1;
    o_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_pack_round.md
# fp_pack_round

Final stage of the dual-mode floating-point add datapath: the write-side counterpart of the operand extraction stage. It takes a sign / exponent / 53-bit fraction result, with guard-round-sticky bits and special-case flags, and performs round-to-nearest-even. It then packs either one IEEE-754 double or two independent singles into a 64-bit word. It is a 2-stage pipeline with valid/ready handshake on both sides.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  input transaction present.
- `i_ready`  out  1  stage can accept input this cycle.
- `i_mode`  in  1  1 = one double (lane 0), 0 = two singles; sampled with each transaction.
- `i_sign`  in  2  per-lane sign; double uses [0].
- `i_exp`  in  16  biased exponents.
  - Single mode: lane0 = [7:0], lane1 = [15:8].
  - Double mode: {[10:8],[7:0]}; [15:11] ignored.
- `i_frac53`  in  53  mantissas including hidden bit.
  - Double: [52] hidden, [51:0] fraction.
  - Single lane0: [23] hidden, [22:0] fraction.
  - Single lane1: [52] hidden, [51:29] fraction; [28:24] ignored.
- `i_grs`  in  6  guard/round/sticky: lane1 = [5:3], lane0 = [2:0]; double uses [2:0].
- `i_nan`, `i_inf`, `i_zero`  in  2 each  per-lane special results; double uses [0].
- `o_valid`  out  1  result present.
- `o_ready`  in  1  downstream accepts.
- `o_result`  out  64  packed result.
  - Double: [63:0].
  - Singles: lane1 = [63:32], lane0 = [31:0].
- `o_flags`  out  4  {ovf1, inx1, ovf0, inx0}; in double mode lane1 bits are 0.

## Operation
- Pipeline enable: `en = o_ready | ~o_valid`. `i_ready = en`.
  - When `en` is high, stage 1 captures the inputs and stage 2 captures stage 1. Valid bits move with the data.
- Stage 1 (round), applied per lane; the double is one 53-bit lane.
  - Round up when `G & (R | S | LSB)`, where LSB is mantissa bit 0.
  - `m' = m + up`, one bit wider than `m`.
  - Carry out of the hidden position: exp += 1, fraction = 0.
  - Input exponent 0 and `m'` hidden bit = 1 (subnormal rounds to normal): exponent becomes 1.
  - Inexact = any GRS bit set.
- Stage 2 (special handling and pack), per lane, in priority order:
  - **NaN:** canonical quiet NaN, sign 0. Single = 0x7FC00000; double = 0x7FF8000000000000.
  - **Inf:** kept sign, exponent all ones, fraction 0.
  - **Zero:** kept sign, exponent 0, fraction 0.
  - **Rounded exponent = all ones** (255 or 2047): signed infinity; set ovf and inx.
  - **Otherwise:** {sign, exp field, fraction without hidden bit}.
- Special flags suppress inx/ovf for that lane.
- Input contract: exponent = 0 iff hidden bit = 0. Behaviour outside this contract is undefined.
- Single-mode lanes are fully independent, with no carry between them.

## Timing
- Latency: 2 cycles from an accepted input (`i_valid & i_ready`) to `o_valid`, provided `o_ready` stays high. Throughput is 1 transaction per cycle.
- Backpressure: when `o_valid & ~o_ready`, the whole pipe holds.
  - `o_result`, `o_flags` and `o_valid` stay stable.
  - `i_ready` = 0.
  - No transaction is lost or duplicated.
- Bubbles travel through the pipe. A stage-1 bubble is not collapsed while stalled.
- Reset state: both valid bits 0, `o_valid` = 0, `o_result` = 0, `o_flags` = 0, `i_ready` = 1 (follows from `o_valid` = 0).
- Reset mid-transfer discards all in-flight transactions immediately (asynchronous). The first input accepted after reset appears 2 cycles later.
- Simultaneous input acceptance and output consumption is a normal pipeline shift.

## Test plan
- **Double normal:** mode=1, sign=0, exp=0x3FF, frac53=1<<52, grs=000 -> 2 cycles later `o_result`=0x3FF0000000000000, flags=0.
- **Two singles:**
  - Lane1: sign=0, exp=0x7F, hidden only.
  - Lane0: sign=1, exp=0x80, hidden only.
  - -> `o_result`=0x3F800000C0000000.
- **Rounding carry:**
  - Lane0 exp=0x7F, mantissa=0xFFFFFF, grs=100 -> 0x40000000, inx0=1.
  - Same case with mantissa=0x800000 (LSB=0, tie) -> 0x3F800000, inx0=1.
- **Overflow:** double exp=0x7FE, mantissa all ones, grs=110 -> 0x7FF0000000000000, ovf0=inx0=1.
- **Specials:**
  - Lane1 nan=1 and inf=1 -> 0x7FC00000.
  - Lane0 zero=1, sign=1 -> 0x80000000.
  - Both flags=0.
- **Backpressure and reset:** stream 4 transactions with `o_ready` low for 3 cycles mid-stream.
  - All 4 arrive in order with held values.
  - `i_ready` is low during the stall.
  - Assert `rst` with 2 transactions in flight -> `o_valid` drops immediately and neither transaction appears.
